// File: rtl/noc_vc_input_buffer_pkg.sv
// rtl/noc_vc_input_buffer_pkg.sv - shared NoC parameters and per-VC state type for the VC input buffer
package noc_vc_input_buffer_pkg;

    localparam int Noc_VC_Channel    = 4;
    localparam int Noc_Data_Width    = 8;
    localparam int Noc_VC_Fifo_Depth = 4;

    typedef enum logic [1:0] {
        VC_IDLE,
        VC_BUSY,
        VC_DRAIN
    } vc_state_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// rtl/noc_vc_fifo.sv - first-word fall-through FIFO with occupancy count, any depth >= 2
module noc_vc_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO never accepts, even when the head is being consumed this cycle.
    assign do_push    = push && (count != CW'(DEPTH));
    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_vc_input_buffer.sv
// rtl/noc_vc_input_buffer.sv - per-VC input FIFOs with packet FSM; optional NOC_VCBUF_PROTOCOL_CHECK_EN error flag
module noc_vc_input_buffer
    import noc_vc_input_buffer_pkg::*;
#(
    parameter int CHANNEL    = Noc_VC_Channel,
    parameter int DATA_WIDTH = Noc_Data_Width,
    parameter int FLIT_NUM   = CHANNEL,
    parameter int FIFO_DEPTH = Noc_VC_Fifo_Depth
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CHANNEL-1:0]                 in_valid,
    output logic [CHANNEL-1:0]                 in_ready,
    input  logic [FLIT_NUM-1:0][DATA_WIDTH-1:0] in_flit,
    input  logic [FLIT_NUM-1:0]                in_is_header,
    input  logic [FLIT_NUM-1:0]                in_is_tail,
    output logic [CHANNEL-1:0]                 in_vc_ready,
    output logic [CHANNEL-1:0]                 out_valid,
    output logic [CHANNEL-1:0][DATA_WIDTH-1:0] out_flit,
    output logic [CHANNEL-1:0]                 out_is_header,
    output logic [CHANNEL-1:0]                 out_is_tail,
    input  logic [CHANNEL-1:0]                 out_pop,
    output logic                               err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef NOC_VCBUF_PROTOCOL_CHECK_EN
    logic [CHANNEL-1:0] push_err;
`endif

    for (genvar v = 0; v < CHANNEL; v++) begin : g_vc
        // With a single shared lane every VC reads lane 0.
        localparam int LANE = (FLIT_NUM == 1) ? 0 : v;

        logic [CW-1:0]         count;
        logic [DATA_WIDTH+1:0] head;
        logic                  head_valid;
        logic                  push;
        logic                  pop;
        logic                  push_hdr;
        logic                  push_tail;
        logic                  vc_ready_q;
        vc_state_t             state;

        assign in_ready[v] = (count != CW'(FIFO_DEPTH));
        assign push        = in_valid[v] & in_ready[v];
        assign pop         = out_pop[v] & head_valid;
        assign push_hdr    = in_is_header[LANE];
        assign push_tail   = in_is_tail[LANE];

        noc_vc_fifo #(
            .WIDTH (DATA_WIDTH + 2),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push),
            .push_data  ({push_hdr, push_tail, in_flit[LANE]}),
            .pop        (pop),
            .head_data  (head),
            .head_valid (head_valid),
            .count      (count)
        );

        assign out_valid[v]                                   = head_valid;
        assign {out_is_header[v], out_is_tail[v], out_flit[v]} = head;
        assign in_vc_ready[v]                                 = vc_ready_q;

        // The VC frees only once its tail has left and nothing else is queued behind it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state      <= VC_IDLE;
                vc_ready_q <= 1'b1;
            end else begin
                case (state)
                    VC_IDLE: begin
                        if (push && push_hdr) begin
                            state      <= push_tail ? VC_DRAIN : VC_BUSY;
                            vc_ready_q <= 1'b0;
                        end
                    end
                    VC_BUSY: begin
                        if (push && push_tail) begin
                            state <= VC_DRAIN;
                        end
                    end
                    VC_DRAIN: begin
                        if (pop && head[DATA_WIDTH] && (count == CW'(1)) && !push) begin
                            state      <= VC_IDLE;
                            vc_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= VC_IDLE;
                        vc_ready_q <= 1'b1;
                    end
                endcase
            end
        end

`ifdef NOC_VCBUF_PROTOCOL_CHECK_EN
        assign push_err[v] = push & ((state == VC_IDLE) ? !push_hdr : push_hdr);
`endif
    end

`ifdef NOC_VCBUF_PROTOCOL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|push_err);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
